counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Programmable sequencer that drives the control inputs of one `counter` instance (enable, mode, step_size, load, load_value) through a table of up to NUM_SEG segments. Each segment loads a start value, then runs the counter in a given mode and step for a fixed number of cycles, or until terminal_flag. It sits between a host/config interface and the counter and raises done and a sticky irq at the end of the program.

Parameters:
- WIDTH, 4, counter data width; sets the widths of step_size and load_value.
- NUM_SEG, 4, number of segment table entries.
- DUR_W, 8, width of the per-segment duration field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  segment table write strobe
- cfg_addr  in  $clog2(NUM_SEG)  table entry index
- cfg_mode  in  2  segment counter mode (opaque, passed to counter mode)
- cfg_step  in  WIDTH  segment step_size
- cfg_load_value  in  WIDTH  segment start value
- cfg_duration  in  DUR_W  enabled cycles; 0 = unlimited
- cfg_stop_on_term  in  1  end segment on terminal_flag
- seg_count  in  $clog2(NUM_SEG+1)  segments in program, sampled at start
- start  in  1  start pulse
- abort  in  1  abort pulse
- irq_clr  in  1  clear sticky irq
- terminal_flag  in  1  from counter
- cnt_enable  out  1  to counter enable
- cnt_mode  out  2  to counter mode
- cnt_step_size  out  WIDTH  to counter step_size
- cnt_load  out  1  to counter load
- cnt_load_value  out  WIDTH  to counter load_value
- busy  out  1  program in progress
- done  out  1  one-cycle completion pulse
- cur_seg  out  $clog2(NUM_SEG)  active segment index
- irq  out  1  sticky completion interrupt
- cfg_err  out  1  one-cycle pulse: write attempted while busy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - The state machine is in IDLE.
  - Segment table contents are cleared to 0.
- Table write: when cfg_we=1 and the block is not busy, the entry at cfg_addr is written on that clock edge.
  - When busy, the write is dropped and cfg_err pulses on the next cycle.
- States: IDLE, LOAD, RUN, NEXT, DONE. busy=1 in LOAD, RUN and NEXT.
- IDLE:
  - cnt_* outputs are 0.
  - start=1 with sampled seg_count>0: cur_seg<=0, go to LOAD.
  - start=1 with seg_count=0: go to DONE (an empty program completes immediately).
  - seg_count > NUM_SEG is clamped to NUM_SEG.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_load_value=table[cur_seg].load_value, cnt_enable=0.
  - The timer is loaded with the entry's duration.
  - Go to RUN.
- RUN:
  - cnt_enable=1; cnt_mode and cnt_step_size come from the entry.
  - The timer decrements each cycle.
  - Exit to NEXT after the cycle in which timer==1, so enable is high for exactly `duration` cycles.
  - Also exit to NEXT when stop_on_term=1 and terminal_flag=1; terminal exit and timer expiry in the same cycle are treated as a single exit.
  - duration=0 means no timer exit; the segment ends only on terminal_flag or abort.
- NEXT (1 cycle):
  - cnt_enable=0.
  - If cur_seg==seg_count-1, go to DONE; otherwise cur_seg++ and go to LOAD.
- DONE (1 cycle): done=1, irq<=1, go to IDLE.
- Outputs cnt_mode and cnt_step_size hold the last segment's values in NEXT, and are 0 in IDLE and DONE.
- abort=1 in any state:
  - Next state is IDLE and all cnt_* outputs are 0 next cycle.
  - No done pulse and no irq.
  - cur_seg is held.
- Simultaneous events:
  - start and abort together: abort wins, stay IDLE.
  - start while busy: ignored.
  - irq set and irq_clr in the same cycle: set wins.
- rst during a run: immediate return to reset values on that edge; the table is cleared.

Optional Feature:
- Macro: COUNTER_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_count [3:0], sampled at start.
  - The program executes loop_count+1 passes.
  - In NEXT on the last segment with passes remaining, cur_seg<=0 and go to LOAD (no done between passes).
  - Adds output pass_idx [3:0].
- Undefined: single pass; loop_count and pass_idx ports are absent.

Decomposition:
- Package counter_seq_pkg:
  - state enum seq_state_e {IDLE, LOAD, RUN, NEXT, DONE}.
  - packed struct seg_cfg_t {mode[1:0], step, load_value, duration, stop_on_term}, parameterized via the package's WIDTH and DUR_W localparams.
- Sub-module counter_seq_table: NUM_SEG-entry register file with synchronous write, combinational read and synchronous clear. The FSM and timer stay in the top module.

Test Plan:
- Single segment (mode=2'b10, step=2, load=1, duration=5), start:
  - cnt_load high 1 cycle with value 1, then cnt_enable high exactly 5 cycles.
  - done pulses 2 cycles after enable falls; irq=1.
- Three segments with durations 3, 4, 2:
  - cur_seg steps 0→1→2.
  - One LOAD cycle and one gap cycle between segments; total busy = 3×2 + 9 = 15 cycles.
- Segment with stop_on_term=1, duration=0:
  - terminal_flag forced high at RUN cycle 6 → NEXT on the following cycle.
  - duration=0 with stop_on_term=0 runs until abort.
- Abort in RUN cycle 2 of a 10-cycle segment:
  - Next cycle cnt_enable=0, busy=0, done=0, irq unchanged.
- Boundary events:
  - cfg_we while busy → cfg_err pulse, entry unchanged.
  - start with seg_count=0 → done pulse, no cnt_load.
  - irq_clr and completion in the same cycle → irq=1.
- COUNTER_SEQ_LOOP_EN, loop_count=2, 2 segments:
  - 6 LOAD pulses, pass_idx 0→1→2, a single done pulse at the end.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and the segment table entry layout.
package counter_seq_pkg;

   localparam int WIDTH = 4;
   localparam int DUR_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      NEXT,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic [1:0]       mode;
      logic [WIDTH-1:0] step;
      logic [WIDTH-1:0] load_value;
      logic [DUR_W-1:0] duration;
      logic             stop_on_term;
   } seg_cfg_t;

endpackage

// File: rtl/counter_seq_table.sv
// Segment table: NUM_SEG entries, synchronous write and clear, combinational read.
module counter_seq_table
   import counter_seq_pkg::*;
#(
   parameter int NUM_SEG = 4,
   parameter int ADDR_W  = $clog2(NUM_SEG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  seg_cfg_t          wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output seg_cfg_t          rd_data
);

   seg_cfg_t mem [NUM_SEG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SEG; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/counter_sequencer.sv
// Segment sequencer driving one counter's control inputs from a programmable table.
// Optional multi-pass looping is enabled by defining COUNTER_SEQ_LOOP_EN.
//
// state | meaning
// IDLE  | waiting for start; counter controls held at 0
// LOAD  | one cycle: cnt_load with the segment start value, timer loaded
// RUN   | counter enabled until timer expiry or terminal_flag
// NEXT  | one gap cycle: advance segment, loop, or finish
// DONE  | one cycle: done pulse, irq set
module counter_sequencer #(
   parameter int WIDTH   = 4,
   parameter int NUM_SEG = 4,
   parameter int DUR_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_SEG)-1:0]   cfg_addr,
   input  logic [1:0]                   cfg_mode,
   input  logic [WIDTH-1:0]             cfg_step,
   input  logic [WIDTH-1:0]             cfg_load_value,
   input  logic [DUR_W-1:0]             cfg_duration,
   input  logic                         cfg_stop_on_term,
   input  logic [$clog2(NUM_SEG+1)-1:0] seg_count,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         irq_clr,
   input  logic                         terminal_flag,
`ifdef COUNTER_SEQ_LOOP_EN
   input  logic [3:0]                   loop_count,
   output logic [3:0]                   pass_idx,
`endif
   output logic                         cnt_enable,
   output logic [1:0]                   cnt_mode,
   output logic [WIDTH-1:0]             cnt_step_size,
   output logic                         cnt_load,
   output logic [WIDTH-1:0]             cnt_load_value,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_SEG)-1:0]   cur_seg,
   output logic                         irq,
   output logic                         cfg_err
);
   import counter_seq_pkg::*;

   localparam int SEG_W = $clog2(NUM_SEG);
   localparam int CNT_W = $clog2(NUM_SEG + 1);

   seq_state_e       state;
   logic [DUR_W-1:0] timer;
   logic [CNT_W-1:0] seg_num;
   logic [CNT_W-1:0] seg_clamp;
   logic [SEG_W-1:0] rd_addr;
   seg_cfg_t         entry;
   seg_cfg_t         wr_entry;
   logic             last_seg;
   logic             run_exit;
   logic             more_pass;

   assign wr_entry  = {cfg_mode, cfg_step, cfg_load_value, cfg_duration, cfg_stop_on_term};
   assign seg_clamp = (seg_count > CNT_W'(NUM_SEG)) ? CNT_W'(NUM_SEG) : seg_count;
   assign last_seg  = (CNT_W'(cur_seg) + CNT_W'(1)) == seg_num;
   assign run_exit  = (timer == DUR_W'(1)) || (entry.stop_on_term && terminal_flag);

   // The read port looks ahead to the entry the next LOAD will need.
   always_comb begin
      rd_addr = cur_seg;
      if (state == IDLE) begin
         rd_addr = '0;
      end else if (state == NEXT) begin
         rd_addr = last_seg ? '0 : cur_seg + SEG_W'(1);
      end
   end

   counter_seq_table #(
      .NUM_SEG (NUM_SEG)
   ) u_table (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we && !busy),
      .wr_addr (cfg_addr),
      .wr_data (wr_entry),
      .rd_addr (rd_addr),
      .rd_data (entry)
   );

`ifdef COUNTER_SEQ_LOOP_EN
   logic [3:0] loop_num;

   assign more_pass = (pass_idx != loop_num);

   always_ff @(posedge clk) begin
      if (rst) begin
         loop_num <= '0;
         pass_idx <= '0;
      end else if (!abort) begin
         if (state == IDLE && start) begin
            loop_num <= loop_count;
            pass_idx <= '0;
         end else if (state == NEXT && last_seg && more_pass) begin
            pass_idx <= pass_idx + 4'd1;
         end
      end
   end
`else
   assign more_pass = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         timer          <= '0;
         seg_num        <= '0;
         cur_seg        <= '0;
         cnt_enable     <= 1'b0;
         cnt_mode       <= '0;
         cnt_step_size  <= '0;
         cnt_load       <= 1'b0;
         cnt_load_value <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         irq            <= 1'b0;
         cfg_err        <= 1'b0;
      end else begin
         cfg_err  <= cfg_we && busy;
         done     <= 1'b0;
         cnt_load <= 1'b0;
         if (state == DONE && !abort) begin
            irq <= 1'b1;
         end else if (irq_clr) begin
            irq <= 1'b0;
         end

         if (abort) begin
            state          <= IDLE;
            busy           <= 1'b0;
            cnt_enable     <= 1'b0;
            cnt_mode       <= '0;
            cnt_step_size  <= '0;
            cnt_load_value <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     seg_num <= seg_clamp;
                     if (seg_clamp == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state          <= LOAD;
                        busy           <= 1'b1;
                        cur_seg        <= '0;
                        cnt_load       <= 1'b1;
                        cnt_load_value <= entry.load_value;
                     end
                  end
               end
               LOAD: begin
                  state         <= RUN;
                  timer         <= entry.duration;
                  cnt_enable    <= 1'b1;
                  cnt_mode      <= entry.mode;
                  cnt_step_size <= entry.step;
               end
               RUN: begin
                  if (timer != '0) begin
                     timer <= timer - DUR_W'(1);
                  end
                  if (run_exit) begin
                     state      <= NEXT;
                     cnt_enable <= 1'b0;
                  end
               end
               NEXT: begin
                  if (last_seg && !more_pass) begin
                     state          <= DONE;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     cnt_mode       <= '0;
                     cnt_step_size  <= '0;
                     cnt_load_value <= '0;
                  end else begin
                     state          <= LOAD;
                     cur_seg        <= last_seg ? '0 : cur_seg + SEG_W'(1);
                     cnt_load       <= 1'b1;
                     cnt_load_value <= entry.load_value;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: expected loads/runs queued at start, checked as the DUT emits them.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [1:0] cfg_mode;
   logic [3:0] cfg_step;
   logic [3:0] cfg_load_value;
   logic [7:0] cfg_duration;
   logic       cfg_stop_on_term;
   logic [2:0] seg_count;
   logic       start;
   logic       abort;
   logic       irq_clr;
   logic       terminal_flag;
   logic       cnt_enable;
   logic [1:0] cnt_mode;
   logic [3:0] cnt_step_size;
   logic       cnt_load;
   logic [3:0] cnt_load_value;
   logic       busy;
   logic       done;
   logic [1:0] cur_seg;
   logic       irq;
   logic       cfg_err;
`ifdef COUNTER_SEQ_LOOP_EN
   logic [3:0] loop_count;
   logic [3:0] pass_idx;
`endif

   always #5 clk = ~clk;

   counter_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_we           (cfg_we),
      .cfg_addr         (cfg_addr),
      .cfg_mode         (cfg_mode),
      .cfg_step         (cfg_step),
      .cfg_load_value   (cfg_load_value),
      .cfg_duration     (cfg_duration),
      .cfg_stop_on_term (cfg_stop_on_term),
      .seg_count        (seg_count),
      .start            (start),
      .abort            (abort),
      .irq_clr          (irq_clr),
      .terminal_flag    (terminal_flag),
`ifdef COUNTER_SEQ_LOOP_EN
      .loop_count       (loop_count),
      .pass_idx         (pass_idx),
`endif
      .cnt_enable       (cnt_enable),
      .cnt_mode         (cnt_mode),
      .cnt_step_size    (cnt_step_size),
      .cnt_load         (cnt_load),
      .cnt_load_value   (cnt_load_value),
      .busy             (busy),
      .done             (done),
      .cur_seg          (cur_seg),
      .irq              (irq),
      .cfg_err          (cfg_err)
   );

   typedef struct {int val; int seg; int pass;} load_t;
   typedef struct {int mode; int step; int len;} run_t;

   load_t load_q[$];
   run_t  run_q[$];

   int m_mode [4];
   int m_step [4];
   int m_lv   [4];
   int m_dur  [4];

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   int busy_cycles = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_en_cyc = 0;
   int run_len = 0;
   bit en_prev = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      chk_cnt++;
      if (obs == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Advance to the next falling edge and run the scoreboard on what the DUT shows there.
   task automatic tick();
      load_t e;
      run_t  r;
      @(negedge clk);
      cyc++;
      if (rst) begin
         if (en_prev && run_q.size() > 0) r = run_q.pop_front();
         en_prev = 1'b0;
      end else begin
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cnt_load) begin
            if (load_q.size() == 0) chk("load_unexpected", 1, 0);
            else begin
               e = load_q.pop_front();
               chk("load_val", int'(cnt_load_value), e.val);
               chk("load_seg", int'(cur_seg), e.seg);
`ifdef COUNTER_SEQ_LOOP_EN
               chk("load_pass", int'(pass_idx), e.pass);
`endif
               chk("load_en_low", int'(cnt_enable), 0);
            end
         end
         if (cnt_enable && !en_prev) begin
            run_len = 0;
            if (run_q.size() == 0) chk("run_unexpected", 1, 0);
            else begin
               chk("run_mode", int'(cnt_mode), run_q[0].mode);
               chk("run_step", int'(cnt_step_size), run_q[0].step);
            end
         end
         if (cnt_enable) begin
            run_len++;
            last_en_cyc = cyc;
         end
         if (!cnt_enable && en_prev && run_q.size() > 0) begin
            r = run_q.pop_front();
            if (r.len >= 0) chk("run_len", run_len, r.len);
         end
         en_prev = cnt_enable;
      end
   endtask

   task automatic write_seg(input int a, input int md, input int st, input int lv,
                            input int dur, input bit sot, input bit upd);
      cfg_addr = 2'(a); cfg_mode = 2'(md); cfg_step = 4'(st);
      cfg_load_value = 4'(lv); cfg_duration = 8'(dur); cfg_stop_on_term = sot;
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      if (upd) begin
         m_mode[a] = md; m_step[a] = st; m_lv[a] = lv; m_dur[a] = dur;
      end
   endtask

   task automatic push_seg(input int s, input int len, input int p);
      load_q.push_back('{m_lv[s], s, p});
      run_q.push_back('{m_mode[s], m_step[s], len});
   endtask

   task automatic start_prog(input int n, input bit push);
      int nc;
      nc = (n > 4) ? 4 : n;
      if (push) begin
         for (int i = 0; i < nc; i++) push_seg(i, (m_dur[i] == 0) ? -1 : m_dur[i], 0);
      end
      seg_count = 3'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, input bit clr);
      int k;
      k = 0;
      while (!done && k < max) begin
         tick();
         k++;
      end
      if (!done) chk("done_timeout", 0, 1);
      else if (clr) begin
         irq_clr = 1'b1;
         tick();
         irq_clr = 1'b0;
      end else tick();
   endtask

   task automatic clear_irq();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0, k;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; cfg_step = '0;
      cfg_load_value = '0; cfg_duration = '0; cfg_stop_on_term = 1'b0;
      seg_count = '0; start = 1'b0; abort = 1'b0; irq_clr = 1'b0; terminal_flag = 1'b0;
`ifdef COUNTER_SEQ_LOOP_EN
      loop_count = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         m_mode[i] = 0; m_step[i] = 0; m_lv[i] = 0; m_dur[i] = 0;
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_irq", int'(irq), 0);
      chk("rst_outs", int'({cnt_enable, cnt_load, cnt_mode, cnt_step_size, cnt_load_value, cur_seg, cfg_err}), 0);

      // single segment
      write_seg(0, 2, 2, 1, 5, 1'b0, 1'b1);
      chk("cfg_err_idle", int'(cfg_err), 0);
      b0 = busy_cycles; d0 = done_cnt;
      start_prog(1, 1'b1);
      wait_done(40, 1'b0);
      chk("single_busy", busy_cycles - b0, 7);
      chk("single_gap", done_cyc - last_en_cyc, 2);
      chk("single_done", done_cnt - d0, 1);
      chk("single_irq", int'(irq), 1);

      // three segments, irq_clr coinciding with completion
      clear_irq();
      chk("irq_clr", int'(irq), 0);
      write_seg(0, 1, 1, 2, 3, 1'b0, 1'b1);
      write_seg(1, 2, 3, 5, 4, 1'b0, 1'b1);
      write_seg(2, 3, 1, 7, 2, 1'b0, 1'b1);
      b0 = busy_cycles;
      start_prog(3, 1'b1);
      wait_done(80, 1'b1);
      chk("irq_set_wins", int'(irq), 1);
      chk("three_busy", busy_cycles - b0, 15);
      clear_irq();

      // terminal exit with unlimited duration
      write_seg(0, 1, 1, 3, 0, 1'b1, 1'b1);
      push_seg(0, 6, 0);
      start_prog(1, 1'b0);
      k = 0;
      for (int i = 0; i < 30 && k < 6; i++) begin
         tick();
         if (cnt_enable) k++;
      end
      chk("term_wait", k, 6);
      terminal_flag = 1'b1;
      tick();
      terminal_flag = 1'b0;
      chk("term_next_en", int'(cnt_enable), 0);
      chk("term_next_busy", int'(busy), 1);
      wait_done(10, 1'b0);
      chk("term_irq", int'(irq), 1);

      // unlimited duration without stop_on_term ends only on abort
      write_seg(0, 2, 1, 4, 0, 1'b0, 1'b1);
      d0 = done_cnt;
      start_prog(1, 1'b1);
      repeat (5) tick();
      terminal_flag = 1'b1;
      repeat (2) tick();
      terminal_flag = 1'b0;
      repeat (20) tick();
      chk("unlim_en", int'(cnt_enable), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("unlim_abort_en", int'(cnt_enable), 0);
      chk("unlim_abort_busy", int'(busy), 0);
      chk("unlim_abort_irq", int'(irq), 1);
      repeat (3) tick();
      chk("unlim_no_done", done_cnt - d0, 0);

      // abort in RUN cycle 2 of a 10-cycle second segment
      clear_irq();
      write_seg(0, 1, 2, 1, 2, 1'b0, 1'b1);
      write_seg(1, 3, 1, 8, 10, 1'b0, 1'b1);
      d0 = done_cnt;
      push_seg(0, 2, 0);
      push_seg(1, -1, 0);
      start_prog(2, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (cnt_load && cur_seg == 2'd1) break;
         tick();
      end
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_en", int'(cnt_enable), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_irq", int'(irq), 0);
      chk("abort_seg_held", int'(cur_seg), 1);
      chk("abort_mode", int'(cnt_mode), 0);
      repeat (3) tick();
      chk("abort_no_done", done_cnt - d0, 0);

      // write while busy is dropped
      write_seg(0, 1, 1, 6, 3, 1'b0, 1'b1);
      start_prog(1, 1'b1);
      tick();
      cfg_addr = 2'd0; cfg_load_value = 4'd9; cfg_duration = 8'd1; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      tick();
      chk("cfg_err_clear", int'(cfg_err), 0);
      wait_done(20, 1'b0);
      start_prog(1, 1'b1);
      wait_done(20, 1'b0);

      // empty program completes immediately
      clear_irq();
      b0 = busy_cycles; d0 = done_cnt;
      start_prog(0, 1'b1);
      wait_done(5, 1'b0);
      chk("empty_done", done_cnt - d0, 1);
      chk("empty_busy", busy_cycles - b0, 0);
      chk("empty_irq", int'(irq), 1);

      // start and abort together
      d0 = done_cnt;
      seg_count = 3'd1; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      repeat (3) tick();
      chk("start_abort_done", done_cnt - d0, 0);

      // seg_count above NUM_SEG clamps to 4
      for (int i = 0; i < 4; i++) write_seg(i, i, i + 1, 10 + i, i + 1, 1'b0, 1'b1);
      b0 = busy_cycles;
      start_prog(7, 1'b1);
      wait_done(80, 1'b0);
      chk("clamp_busy", busy_cycles - b0, 18);

      // reset mid-run clears the table
      start_prog(1, 1'b1);
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      load_q.delete();
      run_q.delete();
      tick();
      chk("rst_run_busy", int'(busy), 0);
      chk("rst_run_en", int'(cnt_enable), 0);
      chk("rst_run_irq", int'(irq), 0);
      for (int i = 0; i < 4; i++) begin
         m_mode[i] = 0; m_step[i] = 0; m_lv[i] = 0; m_dur[i] = 0;
      end
      start_prog(1, 1'b1);
      repeat (10) tick();
      chk("cleared_unlim", int'(cnt_enable), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

`ifdef COUNTER_SEQ_LOOP_EN
      write_seg(0, 1, 1, 2, 2, 1'b0, 1'b1);
      write_seg(1, 2, 1, 3, 3, 1'b0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         push_seg(0, 2, p);
         push_seg(1, 3, p);
      end
      loop_count = 4'd2;
      b0 = busy_cycles; d0 = done_cnt;
      start_prog(2, 1'b0);
      wait_done(100, 1'b0);
      chk("loop_busy", busy_cycles - b0, 27);
      chk("loop_done", done_cnt - d0, 1);
`endif

      chk("load_q_left", load_q.size(), 0);
      chk("run_q_left", run_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
